// File: rtl/mcs4_pkg.sv
// mcs4_pkg: shared definitions for the MCS-4 bus responder models.
//   phase_e      - instruction-cycle phase as seen by a bus responder
//   OPR_* / OPA_* - opcode nibbles recognised by the 4002-class RAM
//   next_phase() - free-running phase sequence (without SYNC override)
//   is_read_opa() - I/O OPA codes that put RAM data on the bus
package mcs4_pkg;

    typedef enum logic [3:0] {
        PH_IDLE,
        PH_A1,
        PH_A2,
        PH_A3,
        PH_M1,
        PH_M2,
        PH_X1,
        PH_X2,
        PH_X3
    } phase_e;

    localparam logic [3:0] OPR_IO  = 4'hE;
    localparam logic [3:0] OPR_SRC = 4'h2;

    localparam logic [3:0] OPA_WRM = 4'h0;
    localparam logic [3:0] OPA_WMP = 4'h1;
    localparam logic [3:0] OPA_WR0 = 4'h4;
    localparam logic [3:0] OPA_SBM = 4'h8;
    localparam logic [3:0] OPA_RDM = 4'h9;
    localparam logic [3:0] OPA_ADM = 4'hB;
    localparam logic [3:0] OPA_RD0 = 4'hC;

    // X3 falls back to IDLE: a responder only re-enters A1 via SYNC.
    function automatic phase_e next_phase(input phase_e p);
        case (p)
            PH_A1:   return PH_A2;
            PH_A2:   return PH_A3;
            PH_A3:   return PH_M1;
            PH_M1:   return PH_M2;
            PH_M2:   return PH_X1;
            PH_X1:   return PH_X2;
            PH_X2:   return PH_X3;
            default: return PH_IDLE;
        endcase
    endfunction

    // SBM and ADM read the same main character as RDM; RD0..RD3 occupy C..F.
    function automatic logic is_read_opa(input logic [3:0] opa);
        return (opa == OPA_SBM) || (opa == OPA_RDM) || (opa == OPA_ADM) ||
               (opa[3:2] == OPA_RD0[3:2]);
    endfunction

endpackage

// File: rtl/mcs4_ram4002_if.sv
// mcs4_ram4002_if: CPU-side control bundle around one 4002-class RAM.
//   phi1, phi2 - two-phase clocks
//   sync       - instruction-cycle sync
//   cm         - CM-RAM select
//   o          - the RAM's 4-bit output port
// The bidirectional data bus stays a plain resolved net at the top level.
interface mcs4_ram4002_if;
    logic       phi1;
    logic       phi2;
    logic       sync;
    logic       cm;
    logic [3:0] o;

    modport master (output phi1, output phi2, output sync, output cm, input  o);
    modport slave  (input  phi1, input  phi2, input  sync, input  cm, output o);
endinterface

// File: rtl/mcs4_phase_tracker.sv
// mcs4_phase_tracker: recovers the 8-phase MCS-4 instruction cycle.
//   clk_i, rst_i   - system clock, async active-high reset
//   phi1_i, phi2_i - phase clocks, sampled on clk_i
//   sync_i         - cycle sync; seen high in one phase forces the next to A1
//   phase_o        - current phase (IDLE after X3 until SYNC)
//   phase_start_o  - one-clk strobe in the first clk of a new phase
//   sample_o       - one-clk strobe on the registered PHI2 falling edge
module mcs4_phase_tracker
    import mcs4_pkg::*;
(
    input  logic   clk_i,
    input  logic   rst_i,
    input  logic   phi1_i,
    input  logic   phi2_i,
    input  logic   sync_i,
    output phase_e phase_o,
    output logic   phase_start_o,
    output logic   sample_o
);

    logic   phi1_q, phi1_d, phi1_prev_q, phi1_prev_d;
    logic   phi2_q, phi2_d, phi2_prev_q, phi2_prev_d;
    logic   sync_q, sync_d, sync_seen_q, sync_seen_d;
    logic   start_q, start_d;
    phase_e phase_q, phase_d;
    logic   phi1_rise;

    always_comb begin
        phi1_d      = phi1_i;
        phi1_prev_d = phi1_q;
        phi2_d      = phi2_i;
        phi2_prev_d = phi2_q;
        sync_d      = sync_i;
        phi1_rise   = phi1_q & ~phi1_prev_q;
        start_d     = phi1_rise;
        phase_d     = phase_q;
        sync_seen_d = sync_seen_q | sync_q;
        if (phi1_rise) begin
            // Only SYNC seen during the phase now ending counts; the sample
            // taken in this very clk opens the sticky flag for the new phase.
            phase_d     = sync_seen_q ? PH_A1 : next_phase(phase_q);
            sync_seen_d = sync_q;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            phi1_q      <= 1'b0;
            phi1_prev_q <= 1'b0;
            phi2_q      <= 1'b0;
            phi2_prev_q <= 1'b0;
            sync_q      <= 1'b0;
            sync_seen_q <= 1'b0;
            start_q     <= 1'b0;
            phase_q     <= PH_IDLE;
        end else begin
            phi1_q      <= phi1_d;
            phi1_prev_q <= phi1_prev_d;
            phi2_q      <= phi2_d;
            phi2_prev_q <= phi2_prev_d;
            sync_q      <= sync_d;
            sync_seen_q <= sync_seen_d;
            start_q     <= start_d;
            phase_q     <= phase_d;
        end
    end

    assign phase_o       = phase_q;
    assign phase_start_o = start_q;
    assign sample_o      = ~phi2_q & phi2_prev_q;

endmodule

// File: rtl/mcs4_ram4002.sv
// mcs4_ram4002: 4002-class data RAM / output port on the MCS-4 bus.
//   CHIP_ID        - matched against D[3:2] of the SRC address nibble
//   clk_i, rst_i   - system clock, async active-high reset
//   PHI1_i, PHI2_i - phase clocks (sampled)
//   SYNC_i, CM_i   - cycle sync and CM-RAM select from the CPU
//   D_io           - shared 4-bit data bus, driven only for reads in X2
//   O_o            - 4-bit output port written by WMP
// Storage: 4 registers x 16 main characters + 4 registers x 4 status nibbles.
module mcs4_ram4002
    import mcs4_pkg::*;
#(
    parameter logic [1:0] CHIP_ID = 2'd0
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       PHI1_i,
    input  logic       PHI2_i,
    input  logic       SYNC_i,
    input  logic       CM_i,
    inout  wire  [3:0] D_io,
    output logic [3:0] O_o
);

    phase_e     phase;
    logic       phase_start;
    logic       sample;
    logic [3:0] d_in;
    logic       d_oe;

    logic [3:0] opr_q, opr_d, opa_q, opa_d;
    logic       io_pend_q, io_pend_d;
    logic       sel_q, sel_d;
    logic       src_hit_q, src_hit_d;
    logic [1:0] reg_q, reg_d;
    logic [3:0] char_q, char_d;
    logic [3:0] out_q, out_d;
    logic [3:0] d_out_q, d_out_d;
    logic [3:0] main_q [64];
    logic [3:0] main_d [64];
    logic [3:0] stat_q [16];
    logic [3:0] stat_d [16];

    mcs4_phase_tracker u_tracker (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .phi1_i        (PHI1_i),
        .phi2_i        (PHI2_i),
        .sync_i        (SYNC_i),
        .phase_o       (phase),
        .phase_start_o (phase_start),
        .sample_o      (sample)
    );

    assign d_in = D_io;

    always_comb begin
        opr_d     = opr_q;
        opa_d     = opa_q;
        io_pend_d = io_pend_q;
        sel_d     = sel_q;
        src_hit_d = src_hit_q;
        reg_d     = reg_q;
        char_d    = char_q;
        out_d     = out_q;
        d_out_d   = d_out_q;
        main_d    = main_q;
        stat_d    = stat_q;

        if (phase_start && phase == PH_A1) begin
            io_pend_d = 1'b0;
            src_hit_d = 1'b0;
        end

        if (sample) begin
            case (phase)
                PH_M1: opr_d = d_in;
                PH_M2: begin
                    opa_d     = d_in;
                    io_pend_d = (opr_q == OPR_IO) && CM_i && sel_q;
                    // Read data is fetched here so the bus can be driven
                    // from the very start of X2 out of a register.
                    if (d_in[3:2] == OPA_RD0[3:2])
                        d_out_d = stat_q[{reg_q, d_in[1:0]}];
                    else
                        d_out_d = main_q[{reg_q, char_q}];
                end
                PH_X2: begin
                    if (io_pend_q) begin
                        if (opa_q == OPA_WRM)
                            main_d[{reg_q, char_q}] = d_in;
                        else if (opa_q == OPA_WMP)
                            out_d = d_in;
                        else if (opa_q[3:2] == OPA_WR0[3:2])
                            stat_d[{reg_q, opa_q[1:0]}] = d_in;
                    end else if (CM_i && opr_q == OPR_SRC && opa_q[0]) begin
                        // A SRC naming another chip deselects this one.
                        sel_d     = (d_in[3:2] == CHIP_ID);
                        src_hit_d = sel_d;
                        if (sel_d)
                            reg_d = d_in[1:0];
                    end
                end
                PH_X3: begin
                    if (src_hit_q) begin
                        char_d    = d_in;
                        src_hit_d = 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            opr_q     <= '0;
            opa_q     <= '0;
            io_pend_q <= 1'b0;
            sel_q     <= 1'b0;
            src_hit_q <= 1'b0;
            reg_q     <= '0;
            char_q    <= '0;
            out_q     <= '0;
            d_out_q   <= '0;
        end else begin
            opr_q     <= opr_d;
            opa_q     <= opa_d;
            io_pend_q <= io_pend_d;
            sel_q     <= sel_d;
            src_hit_q <= src_hit_d;
            reg_q     <= reg_d;
            char_q    <= char_d;
            out_q     <= out_d;
            d_out_q   <= d_out_d;
        end
    end

    for (genvar gi = 0; gi < 64; gi++) begin : g_main
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i)
                main_q[gi] <= '0;
            else
                main_q[gi] <= main_d[gi];
        end
    end

    for (genvar gi = 0; gi < 16; gi++) begin : g_stat
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i)
                stat_q[gi] <= '0;
            else
                stat_q[gi] <= stat_d[gi];
        end
    end

    // Phase is async-reset, so a reset mid-X2 releases the bus at once.
    assign d_oe = (phase == PH_X2) && io_pend_q && is_read_opa(opa_q);
    assign D_io = d_oe ? d_out_q : 4'bzzzz;
    assign O_o  = out_q;

endmodule
